// File: rtl/counter_run_pkg.sv
// Shared types and defaults for the counter run controller.
package counter_run_pkg;

   localparam int unsigned DefInputWidth = 64;
   localparam int unsigned DefRstCycles  = 2;

   typedef enum logic [1:0] {
      StIdle,
      StReset,
      StRun,
      StResp
   } state_e;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Request/response handshake bundle between the SST-side queue (master) and the run controller (slave).
interface counter_run_ctrl_if #(
   parameter int unsigned Width = counter_run_pkg::DefInputWidth
) ();

   logic             req_valid;
   logic             req_ready;
   logic [Width-1:0] req_stop;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [Width-1:0] rsp_cycles;
   logic             rsp_timeout;

   modport master (
      output req_valid, req_stop, rsp_ready,
      input  req_ready, rsp_valid, rsp_cycles, rsp_timeout
   );

   modport slave (
      input  req_valid, req_stop, rsp_ready,
      output req_ready, rsp_valid, rsp_cycles, rsp_timeout
   );

endinterface

// File: rtl/run_ctrl_cycle_cnt.sv
// Clear/increment run-cycle counter; with RUN_CTRL_TIMEOUT_EN it also flags the watchdog terminal count.
module run_ctrl_cycle_cnt #(
   parameter int unsigned Width = 64
`ifdef RUN_CTRL_TIMEOUT_EN
   ,
   parameter int unsigned TermCount = 1024
`endif
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o
`ifdef RUN_CTRL_TIMEOUT_EN
   ,
   output logic             term_o
`endif
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

`ifdef RUN_CTRL_TIMEOUT_EN
   assign term_o = (cnt_q == Width'(TermCount - 1));
`endif

endmodule

// File: rtl/counter_run_ctrl.sv
// Run initiator for the stop-value counter: reset DUT, release, await done, report elapsed cycles.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module counter_run_ctrl
   import counter_run_pkg::*;
#(
   parameter int unsigned InputWidth = DefInputWidth,
   parameter int unsigned RstCycles  = DefRstCycles
`ifdef RUN_CTRL_TIMEOUT_EN
   ,
   parameter int unsigned TimeoutCycles = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  reset_l,
   counter_run_ctrl_if.slave     bus_io,
   output logic                  dut_reset_l_o,
   output logic [InputWidth-1:0] dut_stop_o,
   input  logic                  dut_done_i,
   output logic                  busy_o
);

   localparam int unsigned RstCntW = (RstCycles > 1) ? $clog2(RstCycles) : 1;

   state_e                state_q, state_d;
   logic [RstCntW-1:0]    rst_cnt_q, rst_cnt_d;
   logic                  dut_reset_l_q, dut_reset_l_d;
   logic [InputWidth-1:0] dut_stop_q, dut_stop_d;
   logic [InputWidth-1:0] rsp_cycles_q, rsp_cycles_d;
   logic [InputWidth-1:0] cyc_cnt;
   logic                  rst_last;
   logic                  run_end;

`ifdef RUN_CTRL_TIMEOUT_EN
   logic cyc_term;
   logic rsp_timeout_q, rsp_timeout_d;
`endif

   run_ctrl_cycle_cnt #(
      .Width     (InputWidth)
`ifdef RUN_CTRL_TIMEOUT_EN
      ,
      .TermCount (TimeoutCycles)
`endif
   ) u_cyc_cnt (
      .clk     (clk),
      .reset_l (reset_l),
      .clear_i (state_q != StRun),
      .inc_i   (state_q == StRun),
      .cnt_o   (cyc_cnt)
`ifdef RUN_CTRL_TIMEOUT_EN
      ,
      .term_o  (cyc_term)
`endif
   );

   assign rst_last = (rst_cnt_q == RstCntW'(RstCycles - 1));

`ifdef RUN_CTRL_TIMEOUT_EN
   assign run_end = dut_done_i | cyc_term;
`else
   assign run_end = dut_done_i;
`endif

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus_io.req_valid) state_d = StReset;
         StReset: if (rst_last)         state_d = StRun;
         StRun:   if (run_end)          state_d = StResp;
         StResp:  if (bus_io.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_io.req_ready = (state_q == StIdle);
      bus_io.rsp_valid = (state_q == StResp);
      busy_o           = (state_q != StIdle);
   end

   // DUT is out of reset exactly while the controller sits in RUN.
   always_comb begin
      rst_cnt_d     = (state_q == StReset) ? rst_cnt_q + 1'b1 : '0;
      dut_reset_l_d = (state_d == StRun);
      dut_stop_d    = dut_stop_q;
      if (state_q == StIdle && bus_io.req_valid) begin
         dut_stop_d = bus_io.req_stop;
      end
      rsp_cycles_d = rsp_cycles_q;
      if (state_q == StRun && dut_done_i) begin
         rsp_cycles_d = cyc_cnt;
      end
`ifdef RUN_CTRL_TIMEOUT_EN
      else if (state_q == StRun && cyc_term) begin
         rsp_cycles_d = InputWidth'(TimeoutCycles);
      end
`endif
   end

`ifdef RUN_CTRL_TIMEOUT_EN
   // Done in the same cycle as the terminal count takes priority.
   always_comb begin
      rsp_timeout_d = rsp_timeout_q;
      if (state_q == StRun && dut_done_i) begin
         rsp_timeout_d = 1'b0;
      end else if (state_q == StRun && cyc_term) begin
         rsp_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         rsp_timeout_q <= 1'b0;
      end else begin
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus_io.rsp_timeout = rsp_timeout_q;
`else
   assign bus_io.rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         rst_cnt_q     <= '0;
         dut_reset_l_q <= 1'b0;
         dut_stop_q    <= '0;
         rsp_cycles_q  <= '0;
      end else begin
         rst_cnt_q     <= rst_cnt_d;
         dut_reset_l_q <= dut_reset_l_d;
         dut_stop_q    <= dut_stop_d;
         rsp_cycles_q  <= rsp_cycles_d;
      end
   end

   assign dut_reset_l_o     = dut_reset_l_q;
   assign dut_stop_o        = dut_stop_q;
   assign bus_io.rsp_cycles = rsp_cycles_q;

endmodule
